// File: rtl/montgomery_mult_param.sv
// -----------------------------------------------------------------------------
// montgomery_mult_param
// Radix-2 Montgomery multiplier: result = in_a * in_b * 2^(-WIDTH) mod in_m.
// One bit of in_a is consumed per two-cycle iteration (add B, then add M and
// halve). A single conditional subtraction at the end brings the result below M.
//
// Ports
//   clk     : rising-edge clock
//   resetn  : asynchronous active-low reset
//   start   : operation request, sampled only while idle
//   in_a    : multiplier operand (< in_m), latched on accept
//   in_b    : multiplicand operand (< in_m), latched on accept
//   in_m    : odd modulus (> 1), latched on accept
//   result  : registered product, valid from done until the next SUB state
//   done    : one-cycle completion pulse
//   busy    : high from the cycle after accept until the SUB edge
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; operands latched on the accepting edge
// ADD_B   | C += B when A[i] is set
// ADD_M   | make C even by adding M if needed, then halve; advance i
// SUB     | final conditional subtraction into result, raise done
// DONE    | done pulse cycle, return to IDLE
// -----------------------------------------------------------------------------
module montgomery_mult_param #(
    parameter int WIDTH = 1024,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_m,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ADD_B = 3'd1;
    localparam logic [2:0] S_ADD_M = 3'd2;
    localparam logic [2:0] S_SUB   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] result_q, result_d;
    // Two guard bits: C stays below 2M before halving, and C + B < 3M.
    logic [WIDTH+1:0] c_q, c_d;
    logic [WIDTH+1:0] c_plus_m;
    logic [CNT_W-1:0] i_q, i_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        m_d      = m_q;
        result_d = result_q;
        c_d      = c_q;
        i_d      = i_q;
        done_d   = done_q;
        busy_d   = busy_q;
        c_plus_m = c_q + {2'b00, m_q};

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    m_d     = in_m;
                    c_d     = '0;
                    i_d     = '0;
                    busy_d  = 1'b1;
                    state_d = S_ADD_B;
                end
            end
            S_ADD_B: begin
                if (a_q[i_q]) begin
                    c_d = c_q + {2'b00, b_q};
                end
                state_d = S_ADD_M;
            end
            S_ADD_M: begin
                // M is odd, so adding it clears bit 0 and the shift is exact.
                c_d = c_q[0] ? (c_plus_m >> 1) : (c_q >> 1);
                if (i_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_SUB;
                end else begin
                    i_d     = i_q + CNT_W'(1);
                    state_d = S_ADD_B;
                end
            end
            S_SUB: begin
                // C < 2M here, so the difference always fits in WIDTH bits.
                if (c_q >= {2'b00, m_q}) begin
                    result_d = c_q[WIDTH-1:0] - m_q;
                end else begin
                    result_d = c_q[WIDTH-1:0];
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_DONE;
            end
            S_DONE: begin
                done_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            m_q      <= '0;
            result_q <= '0;
            c_q      <= '0;
            i_q      <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            m_q      <= m_d;
            result_q <= result_d;
            c_q      <= c_d;
            i_q      <= i_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign result = result_q;
    assign done   = done_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_montgomery_mult_param.sv
// -----------------------------------------------------------------------------
// tb_montgomery_mult_param
// Directed bench for the Montgomery multiplier. An 8-bit instance runs
// hand-computed vectors (m=13, R=256, R mod 13 = 9, R^-1 mod 13 = 3); a
// 1024-bit instance runs random odd moduli checked by the identity
// result * 2^1024 == a * b (mod m), plus a back-to-back run with start held.
// -----------------------------------------------------------------------------
module tb_montgomery_mult_param;

    localparam int BW = 1024;
    // Accept edge, 2*WIDTH iteration edges, SUB and DONE: one op per 2*W+3.
    localparam int BIG_PERIOD = 2 * BW + 3;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;

    logic          start8 = 1'b0;
    logic [7:0]    a8 = '0, b8 = '0, m8 = '0;
    logic [7:0]    r8;
    logic          d8, bz8;

    logic          startb = 1'b0;
    logic [BW-1:0] ab = '0, bb = '0, mb = '0;
    logic [BW-1:0] rb;
    logic          db, bzb;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    montgomery_mult_param #(.WIDTH(8)) u_dut8 (
        .clk    (clk),
        .resetn (resetn),
        .start  (start8),
        .in_a   (a8),
        .in_b   (b8),
        .in_m   (m8),
        .result (r8),
        .done   (d8),
        .busy   (bz8)
    );

    montgomery_mult_param #(.WIDTH(BW)) u_dut_big (
        .clk    (clk),
        .resetn (resetn),
        .start  (startb),
        .in_a   (ab),
        .in_b   (bb),
        .in_m   (mb),
        .result (rb),
        .done   (db),
        .busy   (bzb)
    );

    task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One 8-bit operation; optionally pulses start at cycles 3 and 10.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m,
                       input logic [7:0] exp, input bit pulse_mid, input string tag);
        int         first_done = 0;
        int         n_done = 0;
        int         n_busy = 0;
        logic       busy_at_done = 1'b1;
        logic [7:0] res_at_done = '0;
        @(negedge clk);
        a8 = a; b8 = b; m8 = m; start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        a8 = ~a; b8 = ~b; m8 = 8'hff;
        for (int n = 1; n <= 24; n++) begin
            @(negedge clk);
            if (pulse_mid) start8 = (n == 3 || n == 10);
            if (bz8 && n <= 17) n_busy++;
            if (d8) begin
                n_done++;
                if (first_done == 0) begin
                    first_done   = n;
                    busy_at_done = bz8;
                    res_at_done  = r8;
                end
            end
        end
        start8 = 1'b0;
        check({tag, "_latency"}, BW'(first_done), BW'(18));
        check({tag, "_done_count"}, BW'(n_done), BW'(1));
        check({tag, "_busy_cycles"}, BW'(n_busy), BW'(17));
        check({tag, "_busy_at_done"}, BW'(busy_at_done), BW'(0));
        check({tag, "_result"}, BW'(res_at_done), BW'(exp));
    endtask

    task automatic golden(input logic [BW-1:0] a, input logic [BW-1:0] b, input logic [BW-1:0] m,
                          input logic [BW-1:0] res, input string tag);
        logic [2*BW-1:0] mw, prod, lhs, rhs;
        mw   = {{BW{1'b0}}, m};
        prod = {{BW{1'b0}}, a} * {{BW{1'b0}}, b};
        lhs  = prod % mw;
        rhs  = {res, {BW{1'b0}}} % mw;
        check({tag, "_below_m"}, BW'(res < m), BW'(1));
        check({tag, "_mont"}, rhs[BW-1:0], lhs[BW-1:0]);
    endtask

    task automatic rand_ops(output logic [BW-1:0] a, output logic [BW-1:0] b, output logic [BW-1:0] m);
        for (int w = 0; w < BW / 32; w++) begin
            m[w*32 +: 32] = $urandom();
            a[w*32 +: 32] = $urandom();
            b[w*32 +: 32] = $urandom();
        end
        m[0]    = 1'b1;
        m[BW-1] = 1'b1;
        a = a % m;
        b = b % m;
    endtask

    task automatic opb(input logic [BW-1:0] a, input logic [BW-1:0] b, input logic [BW-1:0] m,
                       input string tag);
        int            first_done = 0;
        logic [BW-1:0] res = '0;
        @(negedge clk);
        ab = a; bb = b; mb = m; startb = 1'b1;
        @(posedge clk);
        #1;
        startb = 1'b0;
        ab = '0; bb = '0; mb = '0;
        for (int n = 1; n <= 2 * BW + 10 && first_done == 0; n++) begin
            @(negedge clk);
            if (db) begin
                first_done = n;
                res        = rb;
            end
        end
        check({tag, "_latency"}, BW'(first_done), BW'(2 * BW + 2));
        golden(a, b, m, res, tag);
    endtask

    initial begin
        logic [BW-1:0] ra, rbv, rm;
        int            done_at[3];
        logic [BW-1:0] res_at[3];
        int            nd;

        #12;
        check("reset_result8", BW'(r8), BW'(0));
        check("reset_done8", BW'(d8), BW'(0));
        check("reset_busy8", BW'(bz8), BW'(0));
        check("reset_result_big", rb, '0);
        check("reset_done_big", BW'(db), BW'(0));
        check("reset_busy_big", BW'(bzb), BW'(0));
        @(negedge clk);
        resetn = 1'b1;

        op8(8'd5,  8'd7,  8'd13, 8'd1, 1'b0, "m13_5x7");
        op8(8'd9,  8'd7,  8'd13, 8'd7, 1'b0, "m13_9x7");
        op8(8'd1,  8'd1,  8'd13, 8'd3, 1'b0, "m13_1x1");
        op8(8'd12, 8'd12, 8'd13, 8'd3, 1'b0, "m13_12x12");
        op8(8'd0,  8'd12, 8'd13, 8'd0, 1'b0, "m13_0x12");
        op8(8'd5,  8'd7,  8'd13, 8'd1, 1'b1, "ignored_starts");

        // Abort an operation at cycle 6; the previous result (1) must clear.
        @(negedge clk);
        a8 = 8'd12; b8 = 8'd12; m8 = 8'd13; start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        repeat (6) @(negedge clk);
        check("rst_pre_busy", BW'(bz8), BW'(1));
        check("rst_pre_result", BW'(r8), BW'(1));
        resetn = 1'b0;
        #1;
        check("rst_done", BW'(d8), BW'(0));
        check("rst_busy", BW'(bz8), BW'(0));
        check("rst_result", BW'(r8), BW'(0));
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        op8(8'd5, 8'd7, 8'd13, 8'd1, 1'b0, "post_rst");

        for (int k = 0; k < 20; k++) begin
            rand_ops(ra, rbv, rm);
            opb(ra, rbv, rm, $sformatf("big%0d", k));
        end

        // Back-to-back: start held high, three completions.
        rand_ops(ra, rbv, rm);
        @(negedge clk);
        ab = ra; bb = rbv; mb = rm; startb = 1'b1;
        @(posedge clk);
        nd = 0;
        for (int n = 1; n <= 3 * BIG_PERIOD + 20 && nd < 3; n++) begin
            @(negedge clk);
            if (db) begin
                done_at[nd] = n;
                res_at[nd]  = rb;
                nd++;
            end
        end
        startb = 1'b0;
        check("b2b_done_count", BW'(nd), BW'(3));
        if (nd == 3) begin
            check("b2b_first_latency", BW'(done_at[0]), BW'(2 * BW + 2));
            check("b2b_period_1", BW'(done_at[1] - done_at[0]), BW'(BIG_PERIOD));
            check("b2b_period_2", BW'(done_at[2] - done_at[1]), BW'(BIG_PERIOD));
            for (int j = 0; j < 3; j++) golden(ra, rbv, rm, res_at[j], $sformatf("b2b%0d", j));
        end
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
